// File: rtl/c2c_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : c2c_link_ctrl
// Purpose  : Chip-to-chip ring link endpoint. Trains the link against a fixed
//            pattern, runs a lock/ready handshake with the neighbour, then
//            carries DATA_W-bit words both ways under credit-based flow
//            control into a local first-word-fall-through RX FIFO.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            link_*_out                - registered link towards the neighbour
//            link_*_in                 - neighbour's link outputs
//            tx_data/tx_valid/tx_ready - transmit stream from the fabric
//            rx_data/rx_valid/rx_ready - receive stream to the fabric
//            link_up                   - link is in the UP state
//            err_timeout/err_overflow  - one-cycle error pulses
// Revision : 1.0  initial release
// ============================================================================
module c2c_link_ctrl #(
  parameter int unsigned           DATA_W     = 32,
  parameter int unsigned           CREDITS    = 8,
  parameter logic [DATA_W-1:0]     TRAIN_WORD = 32'hBC5AA5BC,
  parameter int unsigned           TRAIN_LEN  = 16,
  parameter int unsigned           TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] link_data_out,
  output logic              link_valid_out,
  output logic              link_credit_out,
  output logic              link_lock_out,
  output logic              link_ready_out,
  input  logic [DATA_W-1:0] link_data_in,
  input  logic              link_valid_in,
  input  logic              link_credit_in,
  input  logic              link_lock_in,
  input  logic              link_ready_in,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              link_up,
  output logic              err_timeout,
  output logic              err_overflow
);

  localparam int CW   = $clog2(CREDITS + 1);
  localparam int AW   = $clog2(CREDITS);
  localparam int PW   = AW + 1;
  localparam int MW   = $clog2(TRAIN_LEN + 1);
  localparam int BW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_TRAIN      = 2'd0,
    ST_LOCKED     = 2'd1,
    ST_READY_WAIT = 2'd2,
    ST_UP         = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [MW-1:0]     match_cnt, match_nxt;
  logic [BW-1:0]     bring_cnt, bring_nxt;
  logic [CW-1:0]     credits, credits_nxt;
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [DATA_W-1:0] mem [CREDITS];

  logic train_match, timeout_hit, loss, up_stay;
  logic tx_fire, pop, push, drop, full;

  assign train_match = (link_data_in == TRAIN_WORD);
  assign timeout_hit = (state != ST_UP) && (bring_cnt == BW'(TIMEOUT - 1));
  assign loss        = (((state == ST_READY_WAIT) || (state == ST_UP)) && !link_lock_in) ||
                       ((state == ST_UP) && !link_ready_in);
  // Staying in UP this cycle: the only condition under which payload,
  // credits and FIFO traffic are honoured. Everything else flushes.
  assign up_stay     = (state == ST_UP) && !loss;

  assign tx_ready    = (state == ST_UP) && (credits != '0);
  assign tx_fire     = tx_valid && tx_ready;

  // Pointers carry an extra wrap bit: equal low bits with differing wrap
  // bits means full.
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop         = rx_valid && rx_ready;
  assign push        = up_stay && link_valid_in && (!full || pop);
  assign drop        = up_stay && link_valid_in && full && !pop;
  assign rx_data     = mem[rd_ptr[AW-1:0]];

  // Next-state logic; link loss and timeout override every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_TRAIN:      if (train_match && (match_cnt == MW'(TRAIN_LEN - 1))) state_nxt = ST_LOCKED;
      ST_LOCKED:     if (link_lock_in)  state_nxt = ST_READY_WAIT;
      ST_READY_WAIT: if (link_ready_in) state_nxt = ST_UP;
      default:       state_nxt = state;
    endcase
    if (loss || timeout_hit) state_nxt = ST_TRAIN;
  end

  always_comb begin
    match_nxt = '0;
    if ((state == ST_TRAIN) && (state_nxt == ST_TRAIN) && !timeout_hit && train_match)
      match_nxt = match_cnt + MW'(1);

    bring_nxt = ((state == ST_UP) || timeout_hit) ? '0 : bring_cnt + BW'(1);

    credits_nxt = '0;
    if ((state == ST_READY_WAIT) && (state_nxt == ST_UP)) begin
      credits_nxt = CW'(CREDITS);
    end else if (up_stay) begin
      credits_nxt = credits;
      if (tx_fire && !link_credit_in)
        credits_nxt = credits - CW'(1);
      else if (!tx_fire && link_credit_in && (credits != CW'(CREDITS)))
        credits_nxt = credits + CW'(1);
    end

    wr_nxt = '0;
    rd_nxt = '0;
    if (up_stay) begin
      wr_nxt = wr_ptr + PW'(push);
      rd_nxt = rd_ptr + PW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_TRAIN;
      match_cnt       <= '0;
      bring_cnt       <= '0;
      credits         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      for (int i = 0; i < int'(CREDITS); i++) mem[i] <= '0;
      rx_valid        <= 1'b0;
      link_data_out   <= '0;
      link_valid_out  <= 1'b0;
      link_credit_out <= 1'b0;
      link_lock_out   <= 1'b0;
      link_ready_out  <= 1'b0;
      link_up         <= 1'b0;
      err_timeout     <= 1'b0;
      err_overflow    <= 1'b0;
    end else begin
      state           <= state_nxt;
      match_cnt       <= match_nxt;
      bring_cnt       <= bring_nxt;
      credits         <= credits_nxt;
      wr_ptr          <= wr_nxt;
      rd_ptr          <= rd_nxt;
      if (push) mem[wr_ptr[AW-1:0]] <= link_data_in;
      rx_valid        <= (wr_nxt != rd_nxt);
      // Outside UP the training pattern is always on the wire; in UP the
      // last payload word is held between transfers.
      if (state_nxt != ST_UP)
        link_data_out <= TRAIN_WORD;
      else if (tx_fire)
        link_data_out <= tx_data;
      link_valid_out  <= tx_fire && up_stay;
      link_credit_out <= pop && up_stay;
      link_lock_out   <= (state_nxt != ST_TRAIN);
      link_ready_out  <= (state_nxt == ST_READY_WAIT) || (state_nxt == ST_UP);
      link_up         <= (state_nxt == ST_UP);
      err_timeout     <= timeout_hit;
      err_overflow    <= drop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_c2c_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_c2c_link_ctrl
// Purpose  : Two cross-connected link endpoints (A, B) plus a third endpoint
//            (C) with a dead peer. Directed stimulus with hand-computed
//            expectations: bring-up, streaming, back-pressure, link loss,
//            RX overflow and bring-up timeout.
// Revision : 1.0  initial release
// ============================================================================
module tb_c2c_link_ctrl;

  localparam logic [31:0] TW = 32'hBC5AA5BC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // A side
  logic [31:0] a_ldo, a_tx_data, a_rx_data;
  logic a_lvo, a_lco, a_llo, a_lro, a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
  logic a_up, a_eto, a_eov;
  // B side
  logic [31:0] b_ldo, b_tx_data, b_rx_data, b_ldi;
  logic b_lvo, b_lco, b_llo, b_lro, b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready;
  logic b_up, b_eto, b_eov, b_lvi, b_lli;
  // C side (dead peer)
  logic [31:0] c_ldo, c_rx_data;
  logic c_lvo, c_lco, c_llo, c_lro, c_tx_ready, c_rx_valid, c_up, c_eto, c_eov;
  logic [31:0] zero32 = '0;
  logic zero1 = 1'b0;

  // Bench overrides on B's inputs
  logic        inj_en = 1'b0, inj_valid = 1'b0, drop_lock = 1'b0;
  logic [31:0] inj_data = '0;
  assign b_ldi = inj_en ? inj_data  : a_ldo;
  assign b_lvi = inj_en ? inj_valid : a_lvo;
  assign b_lli = a_llo & ~drop_lock;

  c2c_link_ctrl u_a (
    .clk(clk), .rst(rst),
    .link_data_out(a_ldo), .link_valid_out(a_lvo), .link_credit_out(a_lco),
    .link_lock_out(a_llo), .link_ready_out(a_lro),
    .link_data_in(b_ldo), .link_valid_in(b_lvo), .link_credit_in(b_lco),
    .link_lock_in(b_llo), .link_ready_in(b_lro),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready),
    .link_up(a_up), .err_timeout(a_eto), .err_overflow(a_eov)
  );

  c2c_link_ctrl u_b (
    .clk(clk), .rst(rst),
    .link_data_out(b_ldo), .link_valid_out(b_lvo), .link_credit_out(b_lco),
    .link_lock_out(b_llo), .link_ready_out(b_lro),
    .link_data_in(b_ldi), .link_valid_in(b_lvi), .link_credit_in(a_lco),
    .link_lock_in(b_lli), .link_ready_in(a_lro),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
    .link_up(b_up), .err_timeout(b_eto), .err_overflow(b_eov)
  );

  c2c_link_ctrl u_c (
    .clk(clk), .rst(rst),
    .link_data_out(c_ldo), .link_valid_out(c_lvo), .link_credit_out(c_lco),
    .link_lock_out(c_llo), .link_ready_out(c_lro),
    .link_data_in(zero32), .link_valid_in(zero1), .link_credit_in(zero1),
    .link_lock_in(zero1), .link_ready_in(zero1),
    .tx_data(zero32), .tx_valid(zero1), .tx_ready(c_tx_ready),
    .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_ready(zero1),
    .link_up(c_up), .err_timeout(c_eto), .err_overflow(c_eov)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitors, all sampled on the falling edge
  logic [31:0] rxq[$];
  int a_eto_n = 0, b_eto_n = 0, a_eov_n = 0, b_eov_n = 0;
  int c_eto_n = 0, c_t1 = 0, c_t2 = 0, c_up_seen = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (b_rx_valid && b_rx_ready) rxq.push_back(b_rx_data);
      if (a_eto) a_eto_n++;
      if (b_eto) b_eto_n++;
      if (a_eov) a_eov_n++;
      if (b_eov) b_eov_n++;
      if (c_up)  c_up_seen++;
      if (c_eto) begin
        if (c_eto_n == 0)      c_t1 = cyc;
        else if (c_eto_n == 1) c_t2 = cyc;
        c_eto_n++;
      end
    end
  end

  int tx_sent = 0;

  // Offer n consecutive words base.. on A's TX stream, bounded by budget cycles.
  task automatic send_words(input int n, input int base, input int budget);
    int  k = 0;
    int  t = 0;
    logic fire;
    while (k < n && t < budget) begin
      @(posedge clk); #1;
      a_tx_valid = 1'b1;
      a_tx_data  = 32'(base + k);
      @(negedge clk);
      fire = a_tx_ready;
      t++;
      if (fire) begin
        k++;
        tx_sent++;
      end
    end
    @(posedge clk); #1;
    a_tx_valid = 1'b0;
    if (k != n) check("send_budget", 64'(k), 64'(n));
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t = 0;
    while (rxq.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    check("rx_count", 64'(rxq.size()), 64'(n));
  endtask

  task automatic wait_both_up(input int budget);
    int t = 0;
    while (!(a_up && b_up) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("relink_up", {62'd0, a_up, b_up}, 64'd3);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first_lock, first_up_a, first_up_b, ov0, mono;
    logic [31:0] ldo1;
    a_tx_valid = 1'b0; a_tx_data = '0; a_rx_ready = 1'b1;
    b_tx_valid = 1'b0; b_tx_data = '0; b_rx_ready = 1'b1;

    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ldo",   64'(a_ldo), 64'd0);
    check("rst_ctl",   {57'd0, a_lvo, a_lco, a_llo, a_lro, a_up, a_eto, a_eov}, 64'd0);
    check("rst_rx",    {31'd0, a_rx_valid, a_rx_data}, 64'd0);
    check("rst_txrdy", 64'(a_tx_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- bring-up: lock after match 16 (cycle 17), up at cycle 19
    first_lock = 0; first_up_a = 0; first_up_b = 0; ldo1 = '0;
    while (cyc < 21) begin
      @(negedge clk);
      if (cyc == 1) ldo1 = a_ldo;
      if (a_llo && first_lock == 0) first_lock = cyc;
      if (a_up && first_up_a == 0)  first_up_a = cyc;
      if (b_up && first_up_b == 0)  first_up_b = cyc;
    end
    check("train_word", 64'(ldo1), 64'(TW));
    check("lock_cycle", 64'(first_lock), 64'd17);
    check("up_a_cycle", 64'(first_up_a), 64'd19);
    check("up_b_cycle", 64'(first_up_b), 64'd19);
    check("up_credits", 64'(u_a.credits), 64'd8);

    // ---- stream 0..99 A->B
    rxq.delete();
    send_words(100, 0, 1000);
    wait_rx(100, 300);
    for (int i = 0; i < 100 && i < rxq.size(); i++) check("stream_word", 64'(rxq[i]), 64'(i));
    check("stream_credits", 64'(u_a.credits), 64'd8);

    // ---- back-pressure: 20 pending, only 8 credits
    rxq.delete();
    tx_sent = 0;
    @(posedge clk); #1;
    b_rx_ready = 1'b0;
    fork
      send_words(20, 100, 400);
      begin
        repeat (40) @(negedge clk);
        check("bp_sent",  64'(tx_sent), 64'd8);
        check("bp_txrdy", 64'(a_tx_ready), 64'd0);
        check("bp_rxcnt", 64'(rxq.size()), 64'd0);
        @(posedge clk); #1;
        b_rx_ready = 1'b1;
      end
    join
    wait_rx(20, 200);
    check("bp_total", 64'(tx_sent), 64'd20);
    for (int i = 0; i < 20 && i < rxq.size(); i++) check("bp_word", 64'(rxq[i]), 64'(100 + i));

    // ---- link loss mid-stream
    rxq.delete();
    fork
      send_words(40, 200, 600);
      begin
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        drop_lock = 1'b1;
        @(posedge clk); #1;
        drop_lock = 1'b0;
        @(negedge clk);
        check("loss_b_up",      64'(b_up), 64'd0);
        check("loss_b_rxvalid", 64'(b_rx_valid), 64'd0);
        check("loss_b_credits", 64'(u_b.credits), 64'd0);
        @(negedge clk);
        check("loss_a_up",      64'(a_up), 64'd0);
        check("loss_a_credits", 64'(u_a.credits), 64'd0);
        wait_both_up(200);
      end
    join
    repeat (20) @(negedge clk);
    mono = 1;
    for (int i = 1; i < rxq.size(); i++) if (rxq[i] <= rxq[i-1]) mono = 0;
    check("loss_order", 64'(mono), 64'd1);
    rxq.delete();
    send_words(10, 300, 200);
    wait_rx(10, 100);
    for (int i = 0; i < 10 && i < rxq.size(); i++) check("relink_word", 64'(rxq[i]), 64'(300 + i));

    // ---- overflow: 9 words into an 8-entry FIFO
    rxq.delete();
    ov0 = b_eov_n;
    check("pre_ovf", 64'(ov0), 64'd0);
    @(posedge clk); #1;
    b_rx_ready = 1'b0;
    inj_en     = 1'b1;
    for (int i = 0; i < 9; i++) begin
      inj_valid = 1'b1;
      inj_data  = 32'hA0 + 32'(i);
      @(posedge clk); #1;
    end
    inj_valid = 1'b0;
    inj_en    = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_pulses",  64'(b_eov_n - ov0), 64'd1);
    check("ovf_rxvalid", 64'(b_rx_valid), 64'd1);
    @(posedge clk); #1;
    b_rx_ready = 1'b1;
    wait_rx(8, 100);
    for (int i = 0; i < 8 && i < rxq.size(); i++) check("ovf_word", 64'(rxq[i]), 64'(32'hA0 + i));
    check("credit_sat", 64'(u_a.credits), 64'd8);

    // ---- timeout instance with dead peer
    while (cyc < 2100) @(negedge clk);
    check("to_first",  64'(c_t1), 64'd1024);
    check("to_second", 64'(c_t2), 64'd2048);
    check("to_count",  64'(c_eto_n), 64'd2);
    check("to_noup",   64'(c_up_seen), 64'd0);
    check("ab_no_timeout", 64'(a_eto_n + b_eto_n), 64'd0);
    check("a_no_ovf",  64'(a_eov_n), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/c2c_link_ctrl.md
# c2c_link_ctrl

Parametrised chip-to-chip link endpoint for one direction pair of the inter-FPGA ring (up or down neighbour). It brings the link up with a training and lock/ready handshake, then carries DATA_W-bit words both ways with credit-based flow control into a local receive FIFO of CREDITS entries. It presents valid/ready streams to the fabric. One instance sits on each ring port of the FPGA top level.

## Interface
- DATA_W, 32: link and stream word width.
- CREDITS, 8: RX FIFO depth and initial TX credit count; power of two, ≥2.
- TRAIN_WORD, 32'hBC5AA5BC: training pattern; must be DATA_W bits wide.
- TRAIN_LEN, 16: consecutive matching training words required before lock.
- TIMEOUT, 1024: bring-up cycle limit.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- link_data_out  out  DATA_W  word to neighbour.
- link_valid_out  out  1  link_data_out carries a payload word.
- link_credit_out  out  1  one-cycle pulse returning one credit.
- link_lock_out / link_ready_out  out  1  local lock / ready status.
- link_data_in, link_valid_in, link_credit_in, link_lock_in, link_ready_in  in  DATA_W,1,1,1,1  neighbour's outputs.
- tx_data  in  DATA_W; tx_valid  in  1; tx_ready  out  1  transmit stream.
- rx_data  out  DATA_W; rx_valid  out  1; rx_ready  in  1  receive stream.
- link_up  out  1  state is UP.
- err_timeout  out  1  one-cycle pulse on bring-up timeout.
- err_overflow  out  1  one-cycle pulse on dropped RX word.

## Operation
- States: TRAIN, LOCKED, READY_WAIT, UP. Reset enters TRAIN.
- TRAIN:
  - link_data_out=TRAIN_WORD, link_valid_out=0, lock/ready outputs 0.
  - Match counter increments when link_data_in==TRAIN_WORD and clears on any mismatch.
  - When the counter reaches TRAIN_LEN: go to LOCKED and set link_lock_out=1.
- LOCKED: keep sending TRAIN_WORD. When link_lock_in=1: set link_ready_out=1 and go to READY_WAIT.
- READY_WAIT: when link_ready_in=1: go to UP and load the TX credit counter with CREDITS.
- UP:
  - tx_ready = (credits≠0).
  - Transfer on tx_valid&tx_ready: link_data_out=tx_data, link_valid_out=1, credits−1.
  - Otherwise link_valid_out=0 and link_data_out holds its last value.
  - link_credit_in=1 gives credits+1, saturating at CREDITS; an excess credit is ignored.
  - A simultaneous send and credit return leaves credits unchanged.
- Receive: link_valid_in=1 in UP writes link_data_in into the RX FIFO.
  - If the FIFO is full, the word is dropped and err_overflow pulses.
  - link_valid_in outside UP is ignored.
- RX FIFO: first-word-fall-through. A pop on rx_valid&rx_ready causes link_credit_out=1 on the next cycle. Simultaneous push and pop is legal when full or empty.
- Link loss: link_lock_in=0 in READY_WAIT or UP, or link_ready_in=0 in UP, causes the following:
  - Go to TRAIN.
  - Flush the RX FIFO.
  - Credits=0.
  - Clear the match counter.
  - Drop link_lock_out/link_ready_out.
  - Any word in flight is lost.
- Timeout: a bring-up counter runs in TRAIN/LOCKED/READY_WAIT and clears in UP. On reaching TIMEOUT: pulse err_timeout, return to TRAIN, and clear the match and bring-up counters.
- Width rules: credit counter is $clog2(CREDITS+1) bits. FIFO pointers are $clog2(CREDITS)+1 bits, with the wrap bit giving full/empty.

## Timing
- All link_* outputs, link_up, rx_valid and err_* are registered.
- tx_ready is combinational from state and credits only.
- Reset values:
  - All outputs are 0, including link_data_out and rx_data.
  - Credits=0, FIFO empty.
  - TRAIN_WORD appears on link_data_out in the first cycle after rst deasserts.
- Latency:
  - A tx handshake in cycle t appears on the link in t+1.
  - link_valid_in in cycle t gives rx_valid in t+1 if the FIFO was empty.
  - A pop in t gives a credit pulse in t+1.
  - link_data_in match number TRAIN_LEN in cycle t gives link_lock_out=1 in t+1.
  - link_ready_in in t gives link_up=1 in t+1.
- Back-to-back bring-up of two instances takes TRAIN_LEN+4 cycles, ±1.
- Full throughput: one word per cycle, sustained when the round-trip credit latency is below CREDITS cycles.
- rst asserted mid-operation overrides everything. State matches post-reset on the next cycle.

## Test plan
- Two instances cross-connected, rst released at cycle 0 → both link_up=1 by cycle 21; no err_* pulses.
- Stream words 0..99 A→B with rx_ready=1 → B's rx_data sequence is 0..99 in order; A's credits return to 8.
- B holds rx_ready=0, A has 20 words pending → exactly 8 words sent, then tx_ready=0. Releasing rx_ready delivers the remaining 12 and the total is 20.
- Peer outputs tied to 0 → err_timeout pulses at cycle 1024 after reset, then again at 2048; link_up stays 0.
- While up, force link_lock_in=0 for 1 cycle mid-stream → link_up=0 next cycle, RX FIFO empty, credits=0. The link re-trains and link_up returns; later data arrives uncorrupted.
- Inject 9 link_valid_in words with rx_ready=0 in UP → 8 stored, one err_overflow pulse, and rx_data yields the first 8 words.
